// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches one 32-bit instruction per
// single-beat AXI read and hands PC/instruction to decode.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready2,
    output logic        valid2,
    output logic [63:0] PC2,
    output logic [31:0] Ins1,
    input  logic        id_flush,
    input  logic        id_jal,
    input  logic [63:0] id_jpc,
    input  logic        ex_resolve,
    input  logic [63:0] ex_next_pc,
    output logic        arvalid,
    output logic [63:0] araddr,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    output logic        rready,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a source keeps valid and its payload stable until that edge.
    // This holds for decode (valid2/ready2), AR (arvalid/arready) and R
    // (rvalid/rready).

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
    localparam logic [1:0] S_WAIT_EX = 2'd3;

    logic [1:0]  state;
    logic [63:0] pc;
    logic        discard;
    logic        wait_pend;

    logic        ex_take;
    logic        flush;
    logic        slot_free;
    logic        issue;
    logic        beat;
    logic        beat_keep;
    logic        in_flight;
    logic [31:0] beat_ins;

    assign dbg_state = state;

    // An execute resolution belongs to an older instruction, so it masks a
    // same-cycle decode flush.
    assign ex_take   = ex_resolve && (state == S_WAIT_EX);
    assign flush     = id_flush && !ex_resolve;
    assign slot_free = !valid2 || ready2;
    assign issue     = (state == S_IDLE) && slot_free && !flush;
    assign beat      = (state == S_DATA) && rvalid;
    assign beat_keep = beat && !discard && !flush;
    assign in_flight = (state == S_ADDR) || ((state == S_DATA) && !beat);

    always_comb begin
        beat_ins = pc[2] ? rdata[63:32] : rdata[31:0];
        if (rresp != 2'b00) begin
            beat_ins = NOP_INS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            wait_pend <= 1'b0;
            valid2    <= 1'b0;
            PC2       <= 64'd0;
            Ins1      <= 32'd0;
            arvalid   <= 1'b0;
            araddr    <= 64'd0;
            rready    <= 1'b0;
        end else begin
            if (flush) begin
                valid2 <= 1'b0;
            end else if (beat_keep) begin
                valid2 <= 1'b1;
                PC2    <= pc;
                Ins1   <= beat_ins;
            end else if (valid2 && ready2) begin
                valid2 <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (flush) begin
                        if (id_jal) begin
                            pc <= id_jpc;
                        end else begin
                            state <= S_WAIT_EX;
                        end
                    end else if (issue) begin
                        arvalid <= 1'b1;
                        araddr  <= {pc[63:3], 3'b000};
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat) begin
                        rready    <= 1'b0;
                        discard   <= 1'b0;
                        wait_pend <= 1'b0;
                        if (flush) begin
                            if (id_jal) begin
                                pc    <= id_jpc;
                                state <= S_IDLE;
                            end else begin
                                state <= S_WAIT_EX;
                            end
                        end else begin
                            if (!discard) begin
                                pc <= pc + 64'd4;
                            end
                            state <= wait_pend ? S_WAIT_EX : S_IDLE;
                        end
                    end
                end
                S_WAIT_EX: begin
                    if (ex_take) begin
                        pc    <= ex_next_pc;
                        state <= S_IDLE;
                    end else if (flush && id_jal) begin
                        pc    <= id_jpc;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // The AR cannot be withdrawn, so a redirect while a read is in
            // flight marks the returning beat for dropping instead.
            if (flush && in_flight) begin
                discard <= 1'b1;
                if (id_jal) begin
                    pc        <= id_jpc;
                    wait_pend <= 1'b0;
                end else begin
                    wait_pend <= 1'b1;
                end
            end
        end
    end

    ar_stable: assert property (@(posedge clk) disable iff (reset)
        arvalid && !arready |=> arvalid && $stable(araddr));

    one_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(arvalid && rready));

endmodule
